// File: rtl/cover_enumerator.sv
// Streams every WIDTH-bit vector that covers a captured target, in ascending order,
// over a valid/ready handshake, then pulses done with the beat count.
module cover_enumerator #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] ain,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] idx,
    output logic             done,
    output logic [WIDTH:0]   total
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ain_q;

    // Next cover above v: increment, then force the target's bits back on.
    function automatic logic [WIDTH-1:0] next_cover(input logic [WIDTH-1:0] v,
                                                    input logic [WIDTH-1:0] mask);
        next_cover = (v + 1'b1) | mask;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ain_q     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            bin       <= '0;
            idx       <= '0;
            done      <= 1'b0;
            total     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ain_q     <= ain;
                        bin       <= ain;
                        idx       <= '0;
                        total     <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (out_valid && out_ready) begin
                        total <= total + 1'b1;
                        if (&bin) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            bin <= next_cover(bin, ain_q);
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cover_enumerator.sv
// Self-checking bench for cover_enumerator: table-driven runs, random targets and
// ready patterns, and hand-written reset / start-ignore sequences.
module tb_cover_enumerator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] ain;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] bin;
    logic [5:0] idx;
    logic       done;
    logic [6:0] total;

    int n_cmp;
    int n_fail;

    cover_enumerator #(.WIDTH(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ain      (ain),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .bin      (bin),
        .idx      (idx),
        .done     (done),
        .total    (total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // mode 0: ready always high; 1: pattern 1,0,0 repeating; 2: random
    function automatic logic pick_ready(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_enum(input logic [5:0] a, input int mode, input bit repulse,
                            input int exp_total);
        logic [5:0] exp_q[$];
        logic [5:0] got_b[$];
        logic [5:0] got_i[$];
        logic [5:0] vv;
        logic [5:0] hb;
        logic [5:0] hi;
        bit         hold;
        bit         seen_done;
        logic       r;

        // Reference: all covers of a, ascending, by exhaustive search.
        for (int v = 0; v < 64; v++) begin
            vv = v[5:0];
            if ((a & ~vv) == 6'd0) exp_q.push_back(vv);
        end

        @(negedge clk);
        start     = 1'b1;
        ain       = a;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        ain   = 6'($urandom);
        check("first_valid", int'(out_valid), 1);
        check("first_busy", int'(busy), 1);
        check("first_bin", int'(bin), int'(a));
        check("first_idx", int'(idx), 0);
        check("first_total", int'(total), 0);

        hold      = 1'b0;
        seen_done = 1'b0;
        hb        = '0;
        hi        = '0;
        for (int k = 0; k < 400; k++) begin
            if (done) begin
                seen_done = 1'b1;
                check("done_total", int'(total), exp_total);
                check("done_valid", int'(out_valid), 0);
                check("done_busy", int'(busy), 1);
                if (repulse) begin
                    start = 1'b1;
                    ain   = 6'd0;
                end
                break;
            end
            if (hold) begin
                check("hold_bin", int'(bin), int'(hb));
                check("hold_idx", int'(idx), int'(hi));
            end
            check("run_valid", int'(out_valid), 1);
            r         = pick_ready(mode, k);
            start     = repulse && (k == 1);
            if (repulse && k == 1) ain = 6'd0;
            out_ready = r;
            if (out_valid && r) begin
                got_b.push_back(bin);
                got_i.push_back(idx);
            end
            hold = out_valid && !r;
            hb   = bin;
            hi   = idx;
            @(negedge clk);
        end
        if (!seen_done) check("done_timeout", 0, 1);

        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        check("after_busy", int'(busy), 0);
        check("after_done", int'(done), 0);
        check("after_valid", int'(out_valid), 0);
        check("after_total", int'(total), exp_total);
        @(negedge clk);
        check("idle_hold_busy", int'(busy), 0);
        check("idle_hold_total", int'(total), exp_total);

        check("beat_count", got_b.size(), exp_q.size());
        for (int j = 0; j < got_b.size() && j < exp_q.size(); j++) begin
            check("beat_bin", int'(got_b[j]), int'(exp_q[j]));
            check("beat_idx", int'(got_i[j]), j);
        end
    endtask

    typedef struct {
        logic [5:0] a;
        int         mode;
        bit         repulse;
        int         exp_total;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [5:0] ra;
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        ain       = 6'd0;
        out_ready = 1'b0;

        vecs[0] = '{6'b000011, 0, 1'b0, 16};
        vecs[1] = '{6'b111111, 0, 1'b0, 1};
        vecs[2] = '{6'b000000, 0, 1'b0, 64};
        vecs[3] = '{6'b100000, 1, 1'b0, 32};
        vecs[4] = '{6'b101011, 0, 1'b1, 4};
        vecs[5] = '{6'b010101, 2, 1'b0, 8};

        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_bin", int'(bin), 0);
        check("rst_idx", int'(idx), 0);
        check("rst_done", int'(done), 0);
        check("rst_total", int'(total), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_valid", int'(out_valid), 0);

        for (int i = 0; i < 6; i++)
            run_enum(vecs[i].a, vecs[i].mode, vecs[i].repulse, vecs[i].exp_total);

        for (int i = 0; i < 6; i++) begin
            ra = 6'($urandom);
            run_enum(ra, 2, 1'b0, 1 << (6 - $countones(ra)));
        end

        // Reset in the middle of a run: asynchronous clear, no done pulse.
        @(negedge clk);
        start     = 1'b1;
        ain       = 6'b000011;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_idx_before_rst", int'(idx), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_bin", int'(bin), 0);
        check("mid_rst_idx", int'(idx), 0);
        check("mid_rst_total", int'(total), 0);
        check("mid_rst_done", int'(done), 0);
        @(negedge clk);
        check("mid_rst_done_hold", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", int'(done), 0);
        check("post_rst_busy", int'(busy), 0);
        run_enum(6'b110111, 0, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/cover_enumerator.md
Name: cover_enumerator

Overview:
- Sequential generator for the 6-bit cover relation: bin covers ain when every 1 bit of ain is also 1 in bin, i.e. (ain & ~bin) == 0.
- On a start request it captures a target vector ain.
- It then streams every vector that covers ain, in ascending numeric order, one per handshake, and signals completion with the total count.
- It supplies stimulus and reference streams for the combinational cover detector and its consumers.

Parameters:
- WIDTH, 6, width of the ain and bin vectors.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin enumeration; sampled only in IDLE.
- ain  input  WIDTH  target vector; captured on the cycle start is accepted.
- busy  output  1  high in RUN and DONE.
- out_valid  output  1  bin/idx hold a valid cover.
- out_ready  input  1  consumer accepts the current beat.
- bin  output  WIDTH  current covering vector.
- idx  output  WIDTH  0-based index of the current beat.
- done  output  1  one-cycle pulse after the last beat is accepted.
- total  output  WIDTH+1  number of beats accepted in the current or last run; held until the next start.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. busy=0, out_valid=0, bin=0, idx=0, done=0, total=0, captured ain_q=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a clock edge: ain_q<=ain, bin<=ain, idx<=0, total<=0, out_valid<=1, state<=RUN.
  - out_valid is therefore high the cycle after start is sampled (latency 1).
  - start=0: remain in IDLE with all outputs held.
- RUN, beat transfer:
  - A beat transfers on a rising edge where out_valid&&out_ready.
  - On each transfer: total<=total+1.
  - If bin==all-ones: out_valid<=0, done<=1, state<=DONE.
  - Otherwise: bin<=(bin+1)|ain_q, idx<=idx+1.
  - The increment wraps modulo 2^WIDTH but is never reached from all-ones.
- Backpressure: out_ready=0 with out_valid=1 holds bin, idx and out_valid unchanged for any number of cycles.
- out_ready may be high while out_valid=0; this has no effect.
- start and ain are ignored in RUN and DONE.
- DONE: lasts exactly one cycle. done=1, busy=1. Next edge: done<=0, state<=IDLE.
- A start asserted during DONE is ignored; it is accepted from IDLE on a later edge.
- Sequence invariants:
  - The first beat is bin=ain_q.
  - Every beat satisfies (ain_q & ~bin)==0 and is strictly greater than the previous beat.
  - Beat count = 2^(WIDTH - popcount(ain_q)), so 1 <= total <= 2^WIDTH.
  - total is WIDTH+1 bits so it can hold 64.
  - idx of the last beat = total-1.
- Reset mid-run: immediate return to IDLE with reset values. No done pulse. Partial total is discarded (reads 0).
- ain changing during RUN does not affect the sequence.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- ain=6'b000011, start pulse, out_ready=1 constantly -> 16 beats: 000011, 000111, 001011, 001111, 010011, ..., 111111; idx 0..15; then a single done pulse with total=16, then busy=0.
- ain=6'b111111 -> exactly one beat, bin=111111, idx=0. done on the cycle after its transfer, total=1.
- ain=6'b000000 -> 64 beats, bin=0..63 consecutively, total=64 (7'b1000000).
- ain=6'b100000, out_ready toggling 1,0,0,1,... -> bin/idx stable while out_ready=0. Transferred sequence exactly 100000, 100001, ..., 111111 (32 beats), no duplicates or skips.
- ain=6'b101011, start re-pulsed mid-run with ain=6'b000000 -> ignored; sequence stays 101011, 101111, 111011, 111111, total=4.
- rst_n pulsed low after 3 beats of ain=6'b000011 -> outputs go to 0 immediately without waiting for a clock, no done pulse. A fresh start with ain=6'b110111 then yields 110111, 111111, total=2.
